// File: rtl/booth_mult_ctrl_if.sv
// rtl/booth_mult_ctrl_if.sv - handshake/control bundle between Booth controller and its datapath
//
// Purpose: groups the start handshake, the two Booth decision bits coming back
// from the datapath and every enable/status line the controller drives.
//
// Ports (signals):
//   start     master -> slave   begin a multiplication
//   q0        master -> slave   datapath Q[0]
//   qm1       master -> slave   datapath Q[-1]
//   busy      slave -> master   controller not idle
//   ld_m      slave -> master   load multiplicand register
//   ld_q      slave -> master   load multiplier register, clear Q[-1]
//   clr_a     slave -> master   clear accumulator
//   add_en    slave -> master   A <= A + M
//   sub_en    slave -> master   A <= A - M
//   shift_en  slave -> master   arithmetic right shift of {A,Q,Q[-1]}
//   done      slave -> master   one-cycle completion pulse
//   count     slave -> master   iterations remaining
interface booth_mult_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             q0;
  logic             qm1;
  logic             busy;
  logic             ld_m;
  logic             ld_q;
  logic             clr_a;
  logic             add_en;
  logic             sub_en;
  logic             shift_en;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output start, q0, qm1,
    input  busy, ld_m, ld_q, clr_a, add_en, sub_en, shift_en, done, count
  );

  modport slave (
    input  start, q0, qm1,
    output busy, ld_m, ld_q, clr_a, add_en, sub_en, shift_en, done, count
  );
endinterface

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - sequencing FSM for a radix-2 Booth multiplier datapath
//
// Purpose: drives load, add/sub and shift enables for an N-iteration Booth
// multiply over a negedge-capturing datapath, and pulses done when {A,Q}
// holds the product. The FSM updates on posedge so every enable has half a
// cycle of setup before the datapath samples it on the following negedge.
//
// Ports:
//   clk   in   clock (FSM on posedge)
//   rst   in   asynchronous, active-low reset
//   bus   slave modport of booth_mult_ctrl_if (start, q0, qm1 in;
//         busy, ld_m, ld_q, clr_a, add_en, sub_en, shift_en, done, count out)
module booth_mult_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SUB,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic busy_d, ld_m_d, ld_q_d, clr_a_d, add_en_d, sub_en_d, shift_en_d, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic. The Booth decision in TEST uses Q[0]/Q[-1] as left by
  // the previous negedge shift, which is why TEST is its own state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = N_CNT;
        state_d = S_TEST;
      end
      S_TEST: begin
        case ({bus.q0, bus.qm1})
          2'b10:   state_d = S_SUB;
          2'b01:   state_d = S_ADD;
          default: state_d = S_SHIFT;
        endcase
      end
      S_ADD: state_d = S_SHIFT;
      S_SUB: state_d = S_SHIFT;
      S_SHIFT: begin
        // Guarded decrement so the counter can never wrap below zero.
        if (count_q != '0) count_d = count_q - 1'b1;
        if (count_q <= CNT_W'(1)) state_d = S_DONE;
        else                      state_d = S_TEST;
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Moore output decode: purely from state_q, so the async reset forces
  // every output low immediately.
  always_comb begin
    busy_d     = 1'b0;
    ld_m_d     = 1'b0;
    ld_q_d     = 1'b0;
    clr_a_d    = 1'b0;
    add_en_d   = 1'b0;
    sub_en_d   = 1'b0;
    shift_en_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        busy_d  = 1'b1;
        ld_m_d  = 1'b1;
        ld_q_d  = 1'b1;
        clr_a_d = 1'b1;
      end
      S_TEST: busy_d = 1'b1;
      S_ADD: begin
        busy_d   = 1'b1;
        add_en_d = 1'b1;
      end
      S_SUB: begin
        busy_d   = 1'b1;
        sub_en_d = 1'b1;
      end
      S_SHIFT: begin
        busy_d     = 1'b1;
        shift_en_d = 1'b1;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy_d;
  assign bus.ld_m     = ld_m_d;
  assign bus.ld_q     = ld_q_d;
  assign bus.clr_a    = clr_a_d;
  assign bus.add_en   = add_en_d;
  assign bus.sub_en   = sub_en_d;
  assign bus.shift_en = shift_en_d;
  assign bus.done     = done_d;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - self-checking bench for booth_mult_ctrl with a negedge Booth datapath
module tb_booth_mult_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_mult_ctrl_if #(.CNT_W(4)) bus ();

  booth_mult_ctrl #(.N(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Negedge datapath. A carries one extra sign bit so that -128 * -128 does
  // not overflow the accumulator; the product is {A[7:0], Q}.
  logic [8:0] a_r;
  logic [7:0] q_r, m_r;
  logic       qm1_r;
  logic [7:0] m_in, q_in;

  always @(negedge clk) begin
    if (bus.ld_m) m_r <= m_in;
    if (bus.ld_q) begin
      q_r   <= q_in;
      qm1_r <= 1'b0;
    end
    if (bus.clr_a)    a_r <= 9'd0;
    if (bus.add_en)   a_r <= a_r + {m_r[7], m_r};
    if (bus.sub_en)   a_r <= a_r - {m_r[7], m_r};
    if (bus.shift_en) {a_r, q_r, qm1_r} <= {a_r[8], a_r, q_r};
  end

  assign bus.q0  = q_r[0];
  assign bus.qm1 = qm1_r;

  int total = 0;
  int bad   = 0;

  int ops_q[$];   // 1 = ADD cycle, 2 = SUB cycle, in order
  int cnt_q[$];   // count value seen during each SHIFT cycle

  // Runs one multiplication; collects observations only, checks live in tests.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input bit extra_starts,
                        output int lat, output int n_add, output int n_sub, output int n_done,
                        output int excl_bad, output int post_busy, output logic [15:0] prod,
                        output bit timed_out);
    lat = 0; n_add = 0; n_sub = 0; n_done = 0; excl_bad = 0; post_busy = 0;
    timed_out = 1'b0;
    ops_q.delete();
    cnt_q.delete();
    m_in = m;
    q_in = q;
    bus.start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      bus.start = extra_starts && (lat == 3 || lat == 10);
      if ((32'(bus.add_en) + 32'(bus.sub_en) + 32'(bus.shift_en)) > 1) excl_bad++;
      if (bus.add_en) begin n_add++; ops_q.push_back(1); end
      if (bus.sub_en) begin n_sub++; ops_q.push_back(2); end
      if (bus.shift_en) cnt_q.push_back(int'(bus.count));
      if (bus.done) n_done++;
    end while (!bus.done && lat < 200);
    bus.start = 1'b0;
    if (!bus.done) timed_out = 1'b1;
    prod = {a_r[7:0], q_r};
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
      if (bus.busy) post_busy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.ld_m, bus.ld_q, bus.clr_a, bus.add_en, bus.sub_en, bus.shift_en} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {bus.busy, bus.done, bus.ld_m, bus.ld_q, bus.clr_a, bus.add_en, bus.sub_en, bus.shift_en});
    end
    total++;
    if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_start: got busy=%b want 0", bus.busy); end
    end
  endtask

  task automatic test_zero_multiplier();
    int lat, na, ns, nd, ex, pb;
    logic [15:0] p;
    bit to;
    run_op(8'h03, 8'h00, 1'b0, lat, na, ns, nd, ex, pb, p, to);
    total++; if (to)         begin bad++; $display("FAIL zero_timeout: got timeout want done"); end
    total++; if (lat != 18)  begin bad++; $display("FAIL zero_latency: got %0d want 18", lat); end
    total++; if (na + ns != 0) begin bad++; $display("FAIL zero_addsub: got %0d want 0", na + ns); end
    total++; if (p !== 16'h0000) begin bad++; $display("FAIL zero_product: got %h want 0000", p); end
    total++; if (nd != 1)    begin bad++; $display("FAIL zero_done_pulse: got %0d want 1", nd); end
    total++; if (ex != 0)    begin bad++; $display("FAIL zero_exclusive: got %0d want 0", ex); end
  endtask

  task automatic test_alternating();
    int lat, na, ns, nd, ex, pb;
    logic [15:0] p;
    bit to;
    run_op(8'h01, 8'h55, 1'b0, lat, na, ns, nd, ex, pb, p, to);
    total++; if (to)        begin bad++; $display("FAIL alt_timeout: got timeout want done"); end
    total++; if (lat != 26) begin bad++; $display("FAIL alt_latency: got %0d want 26", lat); end
    total++; if (p !== 16'h0055) begin bad++; $display("FAIL alt_product: got %h want 0055", p); end
    total++; if (na != 4 || ns != 4) begin bad++; $display("FAIL alt_counts: got add=%0d sub=%0d want 4/4", na, ns); end
    total++; if (ops_q.size() != 8) begin bad++; $display("FAIL alt_ops_len: got %0d want 8", ops_q.size()); end
    for (int i = 0; i < ops_q.size() && i < 8; i++) begin
      total++;
      if (ops_q[i] != ((i % 2 == 0) ? 2 : 1)) begin
        bad++;
        $display("FAIL alt_order[%0d]: got %0d want %0d", i, ops_q[i], (i % 2 == 0) ? 2 : 1);
      end
    end
    total++; if (ex != 0) begin bad++; $display("FAIL alt_exclusive: got %0d want 0", ex); end
  endtask

  task automatic test_signed();
    int lat, na, ns, nd, ex, pb;
    logic [15:0] p;
    bit to;
    run_op(8'hFD, 8'h05, 1'b0, lat, na, ns, nd, ex, pb, p, to);
    total++; if (to)        begin bad++; $display("FAIL neg3x5_timeout: got timeout want done"); end
    total++; if (p !== 16'hFFF1) begin bad++; $display("FAIL neg3x5_product: got %h want fff1", p); end
    total++; if (lat != 22) begin bad++; $display("FAIL neg3x5_latency: got %0d want 22", lat); end
    run_op(8'h80, 8'h80, 1'b0, lat, na, ns, nd, ex, pb, p, to);
    total++; if (to)        begin bad++; $display("FAIL min_sq_timeout: got timeout want done"); end
    total++; if (p !== 16'h4000) begin bad++; $display("FAIL min_sq_product: got %h want 4000", p); end
    total++; if (lat != 19) begin bad++; $display("FAIL min_sq_latency: got %0d want 19", lat); end
  endtask

  task automatic test_start_while_busy();
    int lat, na, ns, nd, ex, pb;
    logic [15:0] p;
    bit to;
    run_op(8'h02, 8'h03, 1'b1, lat, na, ns, nd, ex, pb, p, to);
    total++; if (to)        begin bad++; $display("FAIL busy_start_timeout: got timeout want done"); end
    total++; if (nd != 1)   begin bad++; $display("FAIL busy_start_dones: got %0d want 1", nd); end
    total++; if (pb != 0)   begin bad++; $display("FAIL busy_start_restart: got busy cycles %0d want 0", pb); end
    total++; if (lat != 20) begin bad++; $display("FAIL busy_start_latency: got %0d want 20", lat); end
    total++; if (p !== 16'h0006) begin bad++; $display("FAIL busy_start_product: got %h want 0006", p); end
    total++; if (cnt_q.size() != 8) begin bad++; $display("FAIL count_seq_len: got %0d want 8", cnt_q.size()); end
    for (int i = 0; i < cnt_q.size() && i < 8; i++) begin
      total++;
      if (cnt_q[i] != 8 - i) begin bad++; $display("FAIL count_seq[%0d]: got %0d want %0d", i, cnt_q[i], 8 - i); end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, na, ns, nd, ex, pb, guard;
    logic [15:0] p;
    bit to;
    m_in = 8'h01;
    q_in = 8'h55;
    bus.start = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      guard++;
    end while (!(bus.add_en && bus.count == 4'd5) && guard < 100);
    total++;
    if (guard >= 100) begin bad++; $display("FAIL midrst_reach_add5: got timeout want ADD with count=5"); end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.ld_m, bus.ld_q, bus.clr_a, bus.add_en, bus.sub_en, bus.shift_en} !== 8'h00) begin
      bad++;
      $display("FAIL midrst_outputs: got %b want 00000000",
               {bus.busy, bus.done, bus.ld_m, bus.ld_q, bus.clr_a, bus.add_en, bus.sub_en, bus.shift_en});
    end
    total++;
    if (bus.count !== 4'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: got busy=%b want 0", bus.busy); end
    run_op(8'hFD, 8'h05, 1'b0, lat, na, ns, nd, ex, pb, p, to);
    total++; if (to)        begin bad++; $display("FAIL midrst_rerun_timeout: got timeout want done"); end
    total++; if (p !== 16'hFFF1) begin bad++; $display("FAIL midrst_rerun_product: got %h want fff1", p); end
    total++; if (lat != 22) begin bad++; $display("FAIL midrst_rerun_latency: got %0d want 22", lat); end
  endtask

  task automatic test_back_to_back();
    int guard;
    m_in = 8'h07;
    q_in = 8'h06;
    bus.start = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!bus.done && guard < 100);
    total++;
    if (!bus.done) begin bad++; $display("FAIL b2b_first_done: got timeout want done"); end
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got busy=%b want 0", bus.busy); end
    @(posedge clk);
    #1;
    total++;
    if (bus.ld_m !== 1'b1) begin bad++; $display("FAIL b2b_reload: got ld_m=%b want 1", bus.ld_m); end
    bus.start = 1'b0;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!bus.done && guard < 100);
    total++;
    if (!bus.done) begin bad++; $display("FAIL b2b_second_done: got timeout want done"); end
    total++;
    if ({a_r[7:0], q_r} !== 16'h002A) begin bad++; $display("FAIL b2b_product: got %h want 002a", {a_r[7:0], q_r}); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    m_in = 8'h00;
    q_in = 8'h00;
    test_reset();
    test_zero_multiplier();
    test_alternating();
    test_signed();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
